cpu_sequencer: RTL and testbench

Parametrised multi-cycle control sequencer for the processor: owns the program counter, instruction register and condition flags, and drives the ROM, register-bank and ALU strobes through a FETCH/DECODE/EXECUTE/WRITEBACK state machine. It adds four things the single-width three-state controller lacked:

- asynchronous reset;
- a fetch-ready handshake;
- conditional relative branches on latched ALU flags;
- a HALT state with restart.

---
 rtl/cpu_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns pc, ir and latched ALU flags, and steps
// FETCH/DECODE/EXECUTE/WRITEBACK/HALT while driving ROM, register-bank and ALU strobes.
module cpu_sequencer #(
  parameter int              PC_W     = 8,
  parameter int              INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_valid,
  input  logic [3:0]        flags,
  input  logic              run,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] ir,
  output logic              rom_oeb,
  output logic              ram_ce,
  output logic              ram_rw,
  output logic              alu_execute,
  output logic              wb_en,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_e;

  localparam logic [3:0] OP_BRANCH = 4'hF;
  localparam logic [3:0] OP_HALT   = 4'hE;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [3:0]        flags_q, flags_d;
  logic              rom_oeb_q, rom_oeb_d;
  logic              ram_ce_q, ram_ce_d;
  logic              ram_rw_q, ram_rw_d;
  logic              alu_execute_q, alu_execute_d;
  logic              wb_en_q, wb_en_d;
  logic              halted_q, halted_d;
  logic [3:0]        opcode;
  logic [PC_W-1:0]   branch_off;

  function automatic logic is_alu(input logic [3:0] op);
    return (op != OP_BRANCH) && (op != OP_HALT);
  endfunction

  // flags layout is {N,Z,C,V}
  function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] f);
    logic met;
    case (cond)
      3'd0:    met = 1'b1;
      3'd1:    met = f[2];
      3'd2:    met = ~f[2];
      3'd3:    met = f[1];
      3'd4:    met = ~f[1];
      3'd5:    met = f[3];
      3'd6:    met = f[0];
      3'd7:    met = 1'b0;
      default: met = 1'b0;
    endcase
    return met;
  endfunction

  assign opcode     = ir_q[15:12];
  assign branch_off = PC_W'($signed(ir_q[5:0]));

  // State and datapath registers
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      flags_q <= 4'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (inst_valid) state_d = S_DECODE; else state_d = S_FETCH;
      S_DECODE:    if (opcode == OP_HALT) state_d = S_HALT; else state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      if (run) state_d = S_FETCH; else state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // pc / ir / flag updates; branches test the latched flags, never the live input
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    case (state_q)
      S_FETCH: begin
        if (inst_valid) ir_d = inst; else ir_d = ir_q;
      end
      S_EXECUTE: begin
        if (is_alu(opcode)) flags_d = flags; else flags_d = flags_q;
      end
      S_WRITEBACK: begin
        if ((opcode == OP_BRANCH) && cond_met(ir_q[11:9], flags_q)) pc_d = pc_q + branch_off;
        else pc_d = pc_q + PC_W'(1);
      end
      S_HALT: begin
        if (run) begin
          pc_d    = RESET_PC;
          flags_d = 4'h0;
        end else begin
          pc_d    = pc_q;
          flags_d = flags_q;
        end
      end
      default: ;
    endcase
  end

  // Strobes decoded from the upcoming state so the registered outputs track state_q
  always_comb begin
    rom_oeb_d     = 1'b1;
    ram_ce_d      = 1'b0;
    ram_rw_d      = 1'b0;
    alu_execute_d = 1'b0;
    wb_en_d       = 1'b0;
    halted_d      = 1'b0;
    case (state_d)
      S_FETCH:     rom_oeb_d = 1'b0;
      S_DECODE: begin
        ram_ce_d = 1'b1;
        ram_rw_d = 1'b1;
      end
      S_EXECUTE:   alu_execute_d = 1'b1;
      S_WRITEBACK: begin
        ram_ce_d = 1'b1;
        wb_en_d  = is_alu(ir_d[15:12]);
      end
      S_HALT:      halted_d = 1'b1;
      default:     rom_oeb_d = 1'b0;
    endcase
  end

  // Output strobe registers
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rom_oeb_q     <= 1'b0;
      ram_ce_q      <= 1'b0;
      ram_rw_q      <= 1'b0;
      alu_execute_q <= 1'b0;
      wb_en_q       <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      rom_oeb_q     <= rom_oeb_d;
      ram_ce_q      <= ram_ce_d;
      ram_rw_q      <= ram_rw_d;
      alu_execute_q <= alu_execute_d;
      wb_en_q       <= wb_en_d;
      halted_q      <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign rom_oeb     = rom_oeb_q;
  assign ram_ce      = ram_ce_q;
  assign ram_rw      = ram_rw_q;
  assign alu_execute = alu_execute_q;
  assign wb_en       = wb_en_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed vector table, hand-written reset corner case,
// and randomized instruction stream checked against an instruction-level model.
module tb_cpu_sequencer;

  localparam int PC_W  = 8;
  localparam int PCMOD = 256;

  logic        clock;
  logic        resetb;
  logic [15:0] inst;
  logic        inst_valid;
  logic [3:0]  flags;
  logic        run;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        rom_oeb, ram_ce, ram_rw, alu_execute, wb_en, halted;

  cpu_sequencer #(.PC_W(PC_W), .INST_W(16), .RESET_PC(8'h00)) dut (
    .clock(clock), .resetb(resetb), .inst(inst), .inst_valid(inst_valid),
    .flags(flags), .run(run), .pc(pc), .ir(ir), .rom_oeb(rom_oeb),
    .ram_ce(ram_ce), .ram_rw(ram_rw), .alu_execute(alu_execute),
    .wb_en(wb_en), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // strobe vector {rom_oeb, ram_ce, ram_rw, alu_execute, wb_en, halted}
  localparam logic [5:0] SV_FETCH  = 6'b000000;
  localparam logic [5:0] SV_DEC    = 6'b111000;
  localparam logic [5:0] SV_EXE    = 6'b100100;
  localparam logic [5:0] SV_WB     = 6'b110000;
  localparam logic [5:0] SV_WB_ALU = 6'b110010;
  localparam logic [5:0] SV_HALT   = 6'b100001;
  localparam logic [5:0] SV_RESET  = 6'b000000;

  int n_checks = 0;
  int n_errors = 0;

  // instruction-level reference state
  int         pc_m;
  logic [3:0] flags_m;
  logic [15:0] ir_m;

  typedef struct {
    logic [15:0] ins;
    logic [3:0]  flg;
    int          waits;
    int          exp_pc;
    logic        exp_wb;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [5:0] strobes();
    return {rom_oeb, ram_ce, ram_rw, alu_execute, wb_en, halted};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_taken(input logic [2:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    if (cond == 3'd0) return 1'b1;
    if (cond == 3'd1) return z;
    if (cond == 3'd2) return !z;
    if (cond == 3'd3) return c;
    if (cond == 3'd4) return !c;
    if (cond == 3'd5) return n;
    if (cond == 3'd6) return v;
    return 1'b0;
  endfunction

  // Entered and left at a falling edge with the DUT in FETCH.
  task automatic run_instr(input logic [15:0] ins, input logic [3:0] fl, input int waits,
                           output int pc_obs, output logic wb_obs);
    int cyc;
    int off;
    logic [3:0] op;
    logic is_alu;
    cyc = 0;
    wb_obs = 1'b0;
    op = ins[15:12];
    is_alu = (op != 4'hF) && (op != 4'hE);
    chk("fetch_pc", 32'(pc), 32'(pc_m));
    chk("fetch_strobes", 32'(strobes()), 32'(SV_FETCH));
    inst_valid = 1'b0;
    for (int w = 0; w < waits; w++) begin
      inst = 16'($urandom);
      @(posedge clock); cyc++;
      @(negedge clock);
      chk("wait_strobes", 32'(strobes()), 32'(SV_FETCH));
      chk("wait_pc", 32'(pc), 32'(pc_m));
      chk("wait_ir", 32'(ir), 32'(ir_m));
    end
    inst = ins;
    inst_valid = 1'b1;
    flags = 4'($urandom);
    @(posedge clock); cyc++;
    @(negedge clock);
    inst = 16'($urandom);
    inst_valid = 1'($urandom);
    run = 1'($urandom);
    chk("decode_strobes", 32'(strobes()), 32'(SV_DEC));
    chk("decode_ir", 32'(ir), 32'(ins));
    ir_m = ins;
    if (op == 4'hE) begin
      run = 1'b0;
      @(posedge clock); cyc++;
      @(negedge clock);
      chk("halt_latency", 32'(cyc), 32'(waits + 2));
      for (int h = 0; h < 3; h++) begin
        chk("halt_strobes", 32'(strobes()), 32'(SV_HALT));
        chk("halt_pc", 32'(pc), 32'(pc_m));
        inst_valid = 1'($urandom);
        @(posedge clock);
        @(negedge clock);
      end
      pc_obs = int'(pc);
      run = 1'b1;
      @(posedge clock);
      @(negedge clock);
      run = 1'b0;
      inst_valid = 1'b0;
      pc_m = 0;
      flags_m = 4'h0;
      chk("restart_strobes", 32'(strobes()), 32'(SV_FETCH));
      chk("restart_pc", 32'(pc), 32'(pc_m));
    end else begin
      @(posedge clock); cyc++;
      @(negedge clock);
      chk("exec_strobes", 32'(strobes()), 32'(SV_EXE));
      flags = fl;
      @(posedge clock); cyc++;
      @(negedge clock);
      flags = 4'($urandom);
      wb_obs = wb_en;
      chk("wb_strobes", 32'(strobes()), 32'(is_alu ? SV_WB_ALU : SV_WB));
      if (is_alu) begin
        flags_m = fl;
        pc_m = (pc_m + 1) % PCMOD;
      end else if (model_taken(ins[11:9], flags_m)) begin
        off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
        pc_m = (pc_m + off + PCMOD) % PCMOD;
      end else begin
        pc_m = (pc_m + 1) % PCMOD;
      end
      @(posedge clock); cyc++;
      @(negedge clock);
      run = 1'b0;
      inst_valid = 1'b0;
      chk("done_strobes", 32'(strobes()), 32'(SV_FETCH));
      chk("done_pc", 32'(pc), 32'(pc_m));
      chk("latency", 32'(cyc), 32'(waits + 4));
      pc_obs = int'(pc);
    end
  endtask

  initial begin
    int   pc_obs;
    logic wb_obs;
    logic [15:0] rins;
    int   r;

    tbl[0]  = '{16'h1000, 4'h0, 0, 1,   1'b1};
    tbl[1]  = '{16'h1200, 4'h0, 0, 2,   1'b1};
    tbl[2]  = '{16'h1400, 4'h0, 5, 3,   1'b1};
    tbl[3]  = '{16'h1000, 4'h4, 0, 4,   1'b1};
    tbl[4]  = '{16'h1000, 4'h4, 0, 5,   1'b1};
    tbl[5]  = '{16'hF23E, 4'h0, 0, 3,   1'b0};
    tbl[6]  = '{16'h1000, 4'h0, 0, 4,   1'b1};
    tbl[7]  = '{16'h1000, 4'h0, 0, 5,   1'b1};
    tbl[8]  = '{16'hF23E, 4'h4, 0, 6,   1'b0};
    tbl[9]  = '{16'hF004, 4'h0, 0, 10,  1'b0};
    tbl[10] = '{16'hFE04, 4'h0, 0, 11,  1'b0};
    tbl[11] = '{16'hF000, 4'h0, 1, 11,  1'b0};
    tbl[12] = '{16'hF034, 4'h0, 0, 255, 1'b0};
    tbl[13] = '{16'h2000, 4'h0, 0, 0,   1'b1};
    tbl[14] = '{16'hF03E, 4'h0, 0, 254, 1'b0};
    tbl[15] = '{16'hF004, 4'h0, 0, 2,   1'b0};
    tbl[16] = '{16'h1000, 4'h0, 0, 3,   1'b1};
    tbl[17] = '{16'h1000, 4'h0, 0, 4,   1'b1};
    tbl[18] = '{16'hE000, 4'h0, 0, 4,   1'b0};

    resetb = 1'b0;
    inst = 16'h0000;
    inst_valid = 1'b0;
    flags = 4'h0;
    run = 1'b0;
    pc_m = 0;
    flags_m = 4'h0;
    ir_m = 16'h0000;

    #2;
    chk("reset_strobes", 32'(strobes()), 32'(SV_RESET));
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_ir", 32'(ir), 32'h0);
    @(negedge clock);
    @(negedge clock);
    resetb = 1'b1;

    // directed vectors
    for (int i = 0; i < 19; i++) begin
      run_instr(tbl[i].ins, tbl[i].flg, tbl[i].waits, pc_obs, wb_obs);
      chk($sformatf("vec%0d_pc", i), 32'(pc_obs), 32'(tbl[i].exp_pc));
      chk($sformatf("vec%0d_wb", i), 32'(wb_obs), 32'(tbl[i].exp_wb));
    end

    // asynchronous reset in the middle of EXECUTE, with Z latched beforehand
    run_instr(16'h1000, 4'h4, 0, pc_obs, wb_obs);
    inst = 16'h1000;
    inst_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    inst_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("pre_reset_exec", 32'(strobes()), 32'(SV_EXE));
    #2;
    resetb = 1'b0;
    run = 1'b1;
    #1;
    chk("async_reset_strobes", 32'(strobes()), 32'(SV_RESET));
    chk("async_reset_pc", 32'(pc), 32'h0);
    chk("async_reset_ir", 32'(ir), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk("reset_hold_strobes", 32'(strobes()), 32'(SV_RESET));
    end
    resetb = 1'b1;
    @(posedge clock);
    @(negedge clock);
    run = 1'b0;
    chk("post_reset_fetch", 32'(strobes()), 32'(SV_FETCH));
    pc_m = 0;
    flags_m = 4'h0;
    ir_m = 16'h0000;
    // Z was cleared by reset, so BRANCH-if-Z must fall through
    run_instr(16'hF23E, 4'h0, 0, pc_obs, wb_obs);
    chk("flags_cleared_branch", 32'(pc_obs), 32'h1);

    // randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) rins = {4'($urandom_range(0, 13)), 12'($urandom)};
      else if (r < 95) rins = {4'hF, 12'($urandom)};
      else rins = {4'hE, 12'($urandom)};
      run_instr(rins, 4'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                pc_obs, wb_obs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
